// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial-line bundle for the UART transmitter.
// The source drives tx_data/tx_valid; the transmitter drives tx_ready, tx and busy.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   modport master (output tx_data, output tx_valid, input tx_ready, input tx, input busy);
   modport slave  (input tx_data, input tx_valid, output tx_ready, output tx, output busy);
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter with a one-byte holding register for gapless back-to-back frames.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
   parameter int CLKS_PER_BIT = 2813,
   parameter int STOP_BITS    = 1,
   parameter int MSB_FIRST    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic     clk,
   input  logic     reset,
   uart_tx_if.slave s_if
);

   localparam int               CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 8191) begin : g_bad_cpb
      $error("uart_tx: CLKS_PER_BIT out of range 2..8191");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (MSB_FIRST < 0 || MSB_FIRST > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_flag
      $error("uart_tx: MSB_FIRST and PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_bit_cnt;
   logic [2:0]      r_data_cnt;
   logic [7:0]      r_shift;
   logic [7:0]      r_hold;
   logic            r_ready;
   logic            r_tx;
   logic            r_busy;

   logic            w_accept;
   logic            w_bit_end;
   logic [7:0]      w_load_byte;
   logic [7:0]      w_shift_nxt;
   logic            w_cur_bit;
   logic            w_nxt_bit;

   assign w_accept    = s_if.tx_valid && r_ready;
   assign w_bit_end   = (r_bit_cnt == BIT_LAST);
   // Holding register has priority; when it is empty the live input is the only source.
   assign w_load_byte = r_ready ? s_if.tx_data : r_hold;
   assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
   assign w_cur_bit   = (MSB_FIRST != 0) ? r_shift[7] : r_shift[0];
   assign w_nxt_bit   = (MSB_FIRST != 0) ? w_shift_nxt[7] : w_shift_nxt[0];

`ifdef UART_TX_PARITY_EN
   logic r_parity;
   logic w_load_par;
   assign w_load_par = (^w_load_byte) ^ 1'(PARITY_ODD);
`endif

   assign s_if.tx_ready = r_ready;
   assign s_if.tx       = r_tx;
   assign s_if.busy     = r_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_data_cnt <= '0;
         r_shift    <= '0;
         r_hold     <= '0;
         r_ready    <= 1'b1;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments; a later assignment in this block overrides an earlier one.
         if (w_accept && r_state != IDLE) begin
            r_hold  <= s_if.tx_data;
            r_ready <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               r_tx      <= 1'b1;
               r_busy    <= 1'b0;
               r_bit_cnt <= '0;
               if (w_accept) begin
                  r_shift <= w_load_byte;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= START;
`ifdef UART_TX_PARITY_EN
                  r_parity <= w_load_par;
`endif
               end
            end

            START: begin
               if (w_bit_end) begin
                  r_bit_cnt  <= '0;
                  r_data_cnt <= '0;
                  r_tx       <= w_cur_bit;
                  r_state    <= DATA;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end

            DATA: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  if (r_data_cnt == 3'd7) begin
                     r_data_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_parity;
                     r_state <= PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= STOP;
`endif
                  end else begin
                     r_data_cnt <= r_data_cnt + 3'd1;
                     r_shift    <= w_shift_nxt;
                     r_tx       <= w_nxt_bit;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  r_bit_cnt  <= '0;
                  r_data_cnt <= '0;
                  r_tx       <= 1'b1;
                  r_state    <= STOP;
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end
`endif

            STOP: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  if (r_data_cnt == STOP_LAST) begin
                     r_data_cnt <= '0;
                     // A byte arriving on the final stop edge chains straight into the next frame.
                     if (!r_ready || w_accept) begin
                        r_shift <= w_load_byte;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= w_load_par;
`endif
                     end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                     end
                  end else begin
                     r_data_cnt <= r_data_cnt + 3'd1;
                  end
               end else begin
                  r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end

            default: begin
               r_state   <= IDLE;
               r_tx      <= 1'b1;
               r_busy    <= 1'b0;
               r_bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule
